// File: rtl/ale_pkg.sv
// rtl/ale_pkg.sv - shared candidate type, default geometry and reciprocal generator for ale_topk
package ale_pkg;

  localparam int ALE_PW        = 8;
  localparam int ALE_TOPK      = 4;
  localparam int ALE_IMG_W     = 512;
  localparam int ALE_IMG_H     = 512;
  localparam int CLOG2_TOPK    = $clog2(ALE_TOPK);
  localparam int FRAME_WINDOWS = ALE_IMG_W * ALE_IMG_H;

  // Field width follows the default channel width; the top is built with PW = ALE_PW.
  typedef struct packed {
    logic [ALE_PW-1:0] dark;
    logic [ALE_PW-1:0] r;
    logic [ALE_PW-1:0] g;
    logic [ALE_PW-1:0] b;
  } cand_t;

  function automatic longint unsigned recip_q(input longint unsigned x, input int inv_w);
    longint unsigned full;
    longint unsigned top;
    full = 64'd1 << inv_w;
    top  = full - 64'd1;
    if (x == 64'd0) return top;
    return ((full / x) > top) ? top : (full / x);
  endfunction

endpackage

// File: rtl/ale_min_tree.sv
// rtl/ale_min_tree.sv - N-input unsigned minimum over a flat vector
module ale_min_tree #(
  parameter int N = 9,
  parameter int W = 8
) (
  input  logic [N*W-1:0] vals,
  output logic [W-1:0]   min_val
);

  always_comb begin
    min_val = vals[W-1:0];
    for (int i = 1; i < N; i++) begin
      if (vals[i*W +: W] < min_val) min_val = vals[i*W +: W];
    end
  end

endmodule

// File: rtl/ale_recip_lut.sv
// rtl/ale_recip_lut.sv - constant reciprocal table, PW-bit code to Q0.INV_W
module ale_recip_lut
  import ale_pkg::*;
#(
  parameter int PW    = 8,
  parameter int INV_W = 16
) (
  input  logic [PW-1:0]    x,
  output logic [INV_W-1:0] y
);

  logic [INV_W-1:0] table_q [2**PW];

  for (genvar i = 0; i < 2**PW; i++) begin : g_entry
    assign table_q[i] = INV_W'(recip_q(64'(i), INV_W));
  end

  assign y = table_q[x];

endmodule

// File: rtl/ale_topk.sv
// rtl/ale_topk.sv - atmospheric light estimator: window mins, top-K dark candidates, smoothed A and reciprocals
module ale_topk
  import ale_pkg::*;
#(
  parameter int PW           = ALE_PW,
  parameter int WIN          = 3,
  parameter int IMG_W        = ALE_IMG_W,
  parameter int IMG_H        = ALE_IMG_H,
  parameter int TOPK         = ALE_TOPK,
  parameter int SMOOTH_SHIFT = 0,
  parameter int INV_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [WIN*WIN*3*PW-1:0] in_win,
  output logic [PW-1:0]           a_r,
  output logic [PW-1:0]           a_g,
  output logic [PW-1:0]           a_b,
  output logic [INV_W-1:0]        inv_a_r,
  output logic [INV_W-1:0]        inv_a_g,
  output logic [INV_W-1:0]        inv_a_b,
  output logic                    a_valid,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int NPIX  = WIN * WIN;
  localparam int N_WIN = IMG_W * IMG_H;
  localparam int CNT_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam int K_LOG = $clog2(TOPK);
  localparam int SUM_W = PW + K_LOG;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_WIN - 1);
  localparam logic [INV_W-1:0] INV_RESET = INV_W'(recip_q((64'd1 << PW) - 64'd1, INV_W));

  // Window index and frame framing
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx;
  logic             win_first;
  logic             win_last;

  always_comb begin
    idx       = in_sof ? '0 : cnt_q;
    win_first = (idx == '0);
    win_last  = (idx == LAST_IDX);
  end

  logic [NPIX*PW-1:0] ch_r, ch_g, ch_b;
  logic [PW-1:0]      min_r, min_g, min_b;

  for (genvar k = 0; k < NPIX; k++) begin : g_split
    assign ch_r[k*PW +: PW] = in_win[k*3*PW + 2*PW +: PW];
    assign ch_g[k*PW +: PW] = in_win[k*3*PW + PW +: PW];
    assign ch_b[k*PW +: PW] = in_win[k*3*PW +: PW];
  end

  ale_min_tree #(.N(NPIX), .W(PW)) u_min_r (.vals(ch_r), .min_val(min_r));
  ale_min_tree #(.N(NPIX), .W(PW)) u_min_g (.vals(ch_g), .min_val(min_g));
  ale_min_tree #(.N(NPIX), .W(PW)) u_min_b (.vals(ch_b), .min_val(min_b));

  logic          s1_valid, s1_first, s1_last;
  logic [PW-1:0] s1_r, s1_g, s1_b;
  logic [PW-1:0] dark;

  ale_min_tree #(.N(3), .W(PW)) u_min_dark (.vals({s1_r, s1_g, s1_b}), .min_val(dark));

  logic          s2_valid, s2_first, s2_last;
  logic [PW-1:0] s2_dark, s2_r, s2_g, s2_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        cnt_q    <= win_last ? '0 : idx + 1'b1;
        s1_r     <= min_r;
        s1_g     <= min_g;
        s1_b     <= min_b;
        s1_first <= win_first;
        s1_last  <= win_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dark  <= dark;
        s2_r     <= s1_r;
        s2_g     <= s1_g;
        s2_b     <= s1_b;
        s2_first <= s1_first;
        s2_last  <= s1_last;
      end
    end
  end

  // Sorted candidate list; a new entry lands below every entry whose dark is >= its own
  cand_t           list_q    [TOPK];
  cand_t           list_ins  [TOPK];
  cand_t           list_next [TOPK];
  cand_t           snap_q    [TOPK];
  cand_t           cand;
  logic [TOPK-1:0] stay;
  logic            ins_ok;
  logic            snap_valid;

  always_comb begin
    int   prev;
    logic above;
    cand   = '{dark: s2_dark, r: s2_r, g: s2_g, b: s2_b};
    ins_ok = cand.dark > list_q[TOPK-1].dark;
    for (int j = 0; j < TOPK; j++) begin
      stay[j] = (list_q[j].dark >= cand.dark);
    end
    for (int j = 0; j < TOPK; j++) begin
      prev  = (j > 0) ? j - 1 : 0;
      above = (j == 0) ? 1'b1 : stay[prev];
      if (stay[j])    list_ins[j] = list_q[j];
      else if (above) list_ins[j] = cand;
      else            list_ins[j] = list_q[prev];
    end
    for (int j = 0; j < TOPK; j++) begin
      if (s2_first)    list_next[j] = (j == 0) ? cand : cand_t'('0);
      else if (ins_ok) list_next[j] = list_ins[j];
      else             list_next[j] = list_q[j];
    end
  end

  // The snapshot takes the post-insertion list, so a following frame's clear cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < TOPK; j++) list_q[j] <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= s2_valid && s2_last;
      if (s2_valid) list_q <= list_next;
      if (s2_valid && s2_last) snap_q <= list_next;
    end
  end

  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic             s4_valid;
  logic [PW-1:0]    avg_r, avg_g, avg_b;

  always_comb begin
    sum_r = '0;
    sum_g = '0;
    sum_b = '0;
    for (int j = 0; j < TOPK; j++) begin
      sum_r = sum_r + SUM_W'(snap_q[j].r);
      sum_g = sum_g + SUM_W'(snap_q[j].g);
      sum_b = sum_b + SUM_W'(snap_q[j].b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s4_valid <= 1'b0;
    end else begin
      s4_valid <= snap_valid;
      if (snap_valid) begin
        avg_r <= PW'(sum_r >> K_LOG);
        avg_g <= PW'(sum_g >> K_LOG);
        avg_b <= PW'(sum_b >> K_LOG);
      end
    end
  end

  function automatic logic [PW-1:0] smooth_step(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
    logic signed [PW:0]   diff;
    logic signed [PW:0]   step;
    logic signed [PW+1:0] acc;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = diff >>> SMOOTH_SHIFT;
    acc  = $signed({2'b00, cur}) + $signed({step[PW], step});
    if (acc < 0) return '0;
    if (acc > $signed({2'b00, {PW{1'b1}}})) return '1;
    return acc[PW-1:0];
  endfunction

  logic          first_q;
  logic [PW-1:0] next_r, next_g, next_b;

  always_comb begin
    if (SMOOTH_SHIFT == 0 || first_q) begin
      next_r = avg_r;
      next_g = avg_g;
      next_b = avg_b;
    end else begin
      next_r = smooth_step(a_r, avg_r);
      next_g = smooth_step(a_g, avg_g);
      next_b = smooth_step(a_b, avg_b);
    end
  end

  logic [INV_W-1:0] lut_r, lut_g, lut_b;

  ale_recip_lut #(.PW(PW), .INV_W(INV_W)) u_lut_r (.x(next_r), .y(lut_r));
  ale_recip_lut #(.PW(PW), .INV_W(INV_W)) u_lut_g (.x(next_g), .y(lut_g));
  ale_recip_lut #(.PW(PW), .INV_W(INV_W)) u_lut_b (.x(next_b), .y(lut_b));

  // busy stays up at completion only if a newer frame is already partly accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '1;
      a_g     <= '1;
      a_b     <= '1;
      inv_a_r <= INV_RESET;
      inv_a_g <= INV_RESET;
      inv_a_b <= INV_RESET;
      a_valid <= 1'b0;
      first_q <= 1'b1;
      busy    <= 1'b0;
    end else begin
      a_valid <= s4_valid;
      if (s4_valid) begin
        a_r     <= next_r;
        a_g     <= next_g;
        a_b     <= next_b;
        inv_a_r <= lut_r;
        inv_a_g <= lut_g;
        inv_a_b <= lut_b;
        first_q <= 1'b0;
      end
      if (in_valid)      busy <= 1'b1;
      else if (s4_valid) busy <= (cnt_q != '0);
    end
  end

  assign frame_done = a_valid;

endmodule

// File: tb/tb_ale_topk.sv
// tb/tb_ale_topk.sv - directed/random bench for ale_topk, two instances (no smoothing, SMOOTH_SHIFT=1)
module tb_ale_topk;

  localparam int PW    = 8;
  localparam int NPIX  = 9;
  localparam int WW    = NPIX * 3 * PW;
  localparam int NWIN  = 16;
  localparam int K     = 4;
  localparam int SHIFT1 = 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sof;
  logic [WW-1:0] in_win;

  logic [7:0]  a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;
  logic [15:0] inv_r0, inv_g0, inv_b0, inv_r1, inv_g1, inv_b1;
  logic        av0, fd0, busy0, av1, fd1, busy1;

  always #5 clk = ~clk;

  ale_topk #(.PW(8), .WIN(3), .IMG_W(4), .IMG_H(4), .TOPK(4), .SMOOTH_SHIFT(0), .INV_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_win(in_win),
    .a_r(a_r0), .a_g(a_g0), .a_b(a_b0),
    .inv_a_r(inv_r0), .inv_a_g(inv_g0), .inv_a_b(inv_b0),
    .a_valid(av0), .frame_done(fd0), .busy(busy0)
  );

  ale_topk #(.PW(8), .WIN(3), .IMG_W(4), .IMG_H(4), .TOPK(4), .SMOOTH_SHIFT(SHIFT1), .INV_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_win(in_win),
    .a_r(a_r1), .a_g(a_g1), .a_b(a_b1),
    .inv_a_r(inv_r1), .inv_a_g(inv_g1), .inv_a_b(inv_b1),
    .a_valid(av1), .frame_done(fd1), .busy(busy1)
  );

  int checks = 0;
  int failures = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  int m0 [3];
  int m1 [3];
  bit first1;
  logic [WW-1:0] fr [NWIN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_recip(input int x);
    if (x == 0) return 65535;
    return ((65536 / x) > 65535) ? 65535 : (65536 / x);
  endfunction

  function automatic logic [WW-1:0] uni(input int r, input int g, input int b);
    logic [WW-1:0] w;
    for (int p = 0; p < NPIX; p++) w[p*24 +: 24] = {8'(r), 8'(g), 8'(b)};
    return w;
  endfunction

  task automatic fill_uniform(input int r, input int g, input int b);
    for (int i = 0; i < NWIN; i++) fr[i] = uni(r, g, b);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NWIN; i++) begin
      for (int p = 0; p < NPIX; p++) begin
        for (int c = 0; c < 3; c++) begin
          int base = 40 + (i * 13 + c * 71) % 200;
          fr[i][p*24 + c*8 +: 8] = 8'(base - int'($urandom_range(0, 40)));
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m0[c] = 255;
      m1[c] = 255;
    end
    first1 = 1'b1;
  endtask

  // Top-K: the frame's first window always counts; later ones only if dark > 0 (cleared slots hold 0).
  task automatic model_frame();
    int dk [NWIN+K];
    int cc [NWIN+K][3];
    bit used [NWIN+K];
    int n = 0;
    int avg [3];
    int sum [3];
    for (int i = 0; i < NWIN; i++) begin
      int mn [3];
      for (int c = 0; c < 3; c++) mn[c] = 255;
      for (int p = 0; p < NPIX; p++)
        for (int c = 0; c < 3; c++)
          if (int'(fr[i][p*24 + (2-c)*8 +: 8]) < mn[c]) mn[c] = int'(fr[i][p*24 + (2-c)*8 +: 8]);
      if (i == 0 || (mn[0] > 0 && mn[1] > 0 && mn[2] > 0)) begin
        dk[n] = mn[0];
        if (mn[1] < dk[n]) dk[n] = mn[1];
        if (mn[2] < dk[n]) dk[n] = mn[2];
        for (int c = 0; c < 3; c++) cc[n][c] = mn[c];
        n++;
      end
    end
    for (int k = 0; k < K; k++) begin
      dk[n] = 0;
      for (int c = 0; c < 3; c++) cc[n][c] = 0;
      n++;
    end
    for (int j = 0; j < n; j++) used[j] = 1'b0;
    for (int c = 0; c < 3; c++) sum[c] = 0;
    for (int k = 0; k < K; k++) begin
      int best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || dk[j] > dk[best])) best = j;
      used[best] = 1'b1;
      for (int c = 0; c < 3; c++) sum[c] += cc[best][c];
    end
    for (int c = 0; c < 3; c++) begin
      avg[c] = sum[c] / K;
      m0[c] = avg[c];
      if (first1) m1[c] = avg[c];
      else begin
        int v = m1[c] + ((avg[c] - m1[c]) >>> SHIFT1);
        m1[c] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
      end
    end
    first1 = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (av0) pulses0++;
    if (av1) pulses1++;
  endtask

  task automatic send(input logic [WW-1:0] w, input logic sof);
    in_valid = 1'b1;
    in_win   = w;
    in_sof   = sof;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic sof, input bit gaps);
    for (int i = 0; i < NWIN; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send(fr[i], sof && (i == 0));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a_r0"}, a_r0, m0[0]);
    check({tag, ".a_g0"}, a_g0, m0[1]);
    check({tag, ".a_b0"}, a_b0, m0[2]);
    check({tag, ".inv_r0"}, inv_r0, ref_recip(m0[0]));
    check({tag, ".inv_g0"}, inv_g0, ref_recip(m0[1]));
    check({tag, ".inv_b0"}, inv_b0, ref_recip(m0[2]));
    check({tag, ".a_r1"}, a_r1, m1[0]);
    check({tag, ".a_g1"}, a_g1, m1[1]);
    check({tag, ".a_b1"}, a_b1, m1[2]);
    check({tag, ".inv_r1"}, inv_r1, ref_recip(m1[0]));
    check({tag, ".inv_b1"}, inv_b1, ref_recip(m1[2]));
  endtask

  task automatic expect_result(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("%s.early_av0_%0d", tag, i), av0, 0);
      check($sformatf("%s.early_av1_%0d", tag, i), av1, 0);
    end
    tick();
    check({tag, ".a_valid0"}, av0, 1);
    check({tag, ".frame_done0"}, fd0, 1);
    check({tag, ".busy0_low"}, busy0, 0);
    check({tag, ".a_valid1"}, av1, 1);
    check({tag, ".frame_done1"}, fd1, 1);
    check_outputs(tag);
    tick();
    check({tag, ".a_valid0_drop"}, av0, 0);
    check({tag, ".frame_done0_drop"}, fd0, 0);
  endtask

  task automatic check_reset(input string tag);
    check_outputs(tag);
    check({tag, ".a_valid0"}, av0, 0);
    check({tag, ".frame_done0"}, fd0, 0);
    check({tag, ".busy0"}, busy0, 0);
    check({tag, ".a_valid1"}, av1, 0);
    check({tag, ".busy1"}, busy1, 0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_win = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset.inv_literal", inv_r0, 32'h0101);
    rst = 1'b0;
    tick();

    // smoothing sequence: dut1 expects 200, 150, 125
    fill_uniform(200, 200, 200);
    send_frame(1'b1, 1'b0);
    check("smooth1.busy_mid", busy0, 1);
    model_frame();
    expect_result("smooth1");
    fill_uniform(100, 100, 100);
    send_frame(1'b1, 1'b0);
    model_frame();
    expect_result("smooth2");
    check("smooth2.a_r1_literal", a_r1, 150);
    send_frame(1'b1, 1'b0);
    model_frame();
    expect_result("smooth3");
    check("smooth3.a_r1_literal", a_r1, 125);

    fill_uniform(200, 150, 100);
    send_frame(1'b1, 1'b0);
    model_frame();
    expect_result("uniform");
    check("uniform.inv_g0_literal", inv_g0, 32'h01B4);

    for (int i = 0; i < NWIN; i++) fr[i] = uni(i + 10, i + 20, i + 10);
    send_frame(1'b1, 1'b0);
    model_frame();
    expect_result("ranked");
    check("ranked.a_g0_literal", a_g0, 33);
    check("ranked.inv_r0_literal", inv_r0, 32'h0B21);

    // abort: 7 windows, then a fresh sof frame; nothing may complete while streaming
    p0 = pulses0;
    fill_random();
    for (int i = 0; i < 7; i++) send(fr[i], i == 0);
    fill_random();
    send_frame(1'b1, 1'b0);
    check("abort.no_early_pulse", pulses0 - p0, 0);
    model_frame();
    expect_result("abort");

    fill_random();
    send_frame(1'b1, 1'b0);
    model_frame();
    expect_result("nogap");
    send_frame(1'b1, 1'b1);
    model_frame();
    expect_result("gaps");

    // counter wrap: second frame has no sof and overlaps the first's completion
    p0 = pulses0;
    fill_random();
    send_frame(1'b1, 1'b0);
    model_frame();
    fill_random();
    send_frame(1'b0, 1'b0);
    model_frame();
    expect_result("wrap");
    check("wrap.pulse_count", pulses0 - p0, 2);

    // reset at window 9
    fill_random();
    for (int i = 0; i < 9; i++) send(fr[i], i == 0);
    p0 = pulses0 + pulses1;
    in_valid = 1'b1;
    in_win = fr[9];
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    model_reset();
    check_reset("midrst");
    rst = 1'b0;
    repeat (8) tick();
    check("midrst.no_pulse", (pulses0 + pulses1) - p0, 0);
    fill_random();
    send_frame(1'b1, 1'b1);
    model_frame();
    expect_result("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
